// File: rtl/lut_load_if.sv
// Config, source stream and table write port bundle for the LUT loader.
// master = config/DMA side, slave = controller.
interface lut_load_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
);
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W:0]   cfg_count;
    logic              cfg_abort;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              lut_we;
    logic [ADDR_W-1:0] lut_waddr;
    logic [DATA_W-1:0] lut_wdata;
    logic              busy;
    logic              done;
    logic              tbl_valid;
    logic              err;

    modport master (
        output cfg_start, cfg_base, cfg_count, cfg_abort,
        output s_valid, s_data,
        input  s_ready,
        input  lut_we, lut_waddr, lut_wdata,
        input  busy, done, tbl_valid, err
    );

    modport slave (
        input  cfg_start, cfg_base, cfg_count, cfg_abort,
        input  s_valid, s_data,
        output s_ready,
        output lut_we, lut_waddr, lut_wdata,
        output busy, done, tbl_valid, err
    );
endinterface

// File: rtl/lut_load_ctrl.sv
// Sequences a valid/ready word stream into the 16x24 activation LUT
// and flags when the table is coherent for the lookup lanes.
module lut_load_ctrl #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic     clka,
    input logic     rst,
    lut_load_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CMPL = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              r_tbl_valid;
    logic              r_err;

    logic w_ready;
    logic w_beat;
    logic w_bad;

    // Abort masks ready so a coincident beat is never taken.
    assign w_ready = (r_state == S_LOAD) & ~bus.cfg_abort;
    assign w_beat  = bus.s_valid & w_ready;
    assign w_bad   = (bus.cfg_count == '0) | (bus.cfg_count > L_DEPTH);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_tbl_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_ptr <= bus.cfg_base;
                        r_rem <= bus.cfg_count;
                        r_err <= 1'b0;
                        if (w_bad) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_LOAD;
                            r_tbl_valid <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.cfg_abort) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (w_beat) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_ptr;
                        r_wdata <= bus.s_data;
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_rem   <= r_rem - L_ONE;
                        if (r_rem == L_ONE) begin
                            r_state <= S_CMPL;
                        end
                    end
                end
                S_CMPL: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (bus.cfg_abort) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tbl_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.lut_we    = r_we;
    assign bus.lut_waddr = r_waddr;
    assign bus.lut_wdata = r_wdata;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.tbl_valid = r_tbl_valid;
    assign bus.err       = r_err;
endmodule
